// File: rtl/connect_n_engine.sv
// Two-player Connect-N game engine: board state, cursor, per-turn timer and
// sequential win detection around the last-placed disc.
module connect_n_engine #(
   parameter int unsigned COLS       = 7,
   parameter int unsigned ROWS       = 6,
   parameter int unsigned WIN_LEN    = 4,
   parameter int unsigned TURN_TICKS = 30,
   localparam int unsigned CW        = $clog2(COLS),
   localparam int unsigned RW        = $clog2(ROWS + 1)
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 Left1,
   input  logic                 Right1,
   input  logic                 Drop1,
   input  logic                 Start1,
   input  logic                 Left2,
   input  logic                 Right2,
   input  logic                 Drop2,
   input  logic                 Start2,
   input  logic                 Tick,
   output logic [ROWS*COLS-1:0] board,
   output logic [ROWS*COLS-1:0] colors,
   output logic [CW-1:0]        selected_col,
   output logic                 player,
   output logic                 game_over,
   output logic [1:0]           winner,
   output logic                 timed_out,
   output logic                 illegal_drop,
   output logic [7:0]           turn_left,
   output logic                 start_state,
   output logic                 end_state
);

   localparam int unsigned NCELL = ROWS * COLS;
   localparam int unsigned CIW   = $clog2(NCELL);
   localparam int unsigned MCW   = $clog2(NCELL + 1);

   typedef enum logic [2:0] {
      S_INIT,
      S_START,
      S_MOVE,
      S_PLACE,
      S_CHECK,
      S_END
   } state_t;

   state_t             state_q, state_d;
   logic [NCELL-1:0]   board_q, board_d;
   logic [NCELL-1:0]   colors_q, colors_d;
   logic [CW-1:0]      sel_q, sel_d;
   logic               player_q, player_d;
   logic               over_q, over_d;
   logic [1:0]         winner_q, winner_d;
   logic               tout_q, tout_d;
   logic               illegal_q, illegal_d;
   logic [7:0]         tleft_q, tleft_d;
   logic [RW-1:0]      depth_q [COLS];
   logic [RW-1:0]      depth_d [COLS];
   logic [MCW-1:0]     mcount_q, mcount_d;
   logic [RW-1:0]      row_q, row_d;
   logic [CW-1:0]      col_q, col_d;
   logic [1:0]         dir_q, dir_d;
   logic               win_q, win_d;
   logic               start_q, end_q;

   logic               left_c, right_c, drop_c;
   logic               col_full_c, tick_to_c, win_c;
   logic [CIW-1:0]     cell_c;
   int                 run_cnt_c;

   // Only the side to move is listened to.
   assign left_c  = player_q ? Left2  : Left1;
   assign right_c = player_q ? Right2 : Right1;
   assign drop_c  = player_q ? Drop2  : Drop1;

   assign col_full_c = (depth_q[sel_q] == RW'(ROWS));
   assign tick_to_c  = Tick && (TURN_TICKS != 0) && (tleft_q == 8'd1);
   assign cell_c     = CIW'(int'(depth_q[sel_q]) * int'(COLS) + int'(sel_q));

   // Length of the same-colour line through the last disc along dir_q.
   always_comb begin : run_len
      int   dr, dc, rr, cc;
      logic go;
      dr = 0;
      dc = 1;
      case (dir_q)
         2'd0:    begin dr = 0;  dc = 1; end
         2'd1:    begin dr = 1;  dc = 0; end
         2'd2:    begin dr = 1;  dc = 1; end
         default: begin dr = -1; dc = 1; end
      endcase
      run_cnt_c = 1;
      rr = 0;
      cc = 0;
      go = 1'b0;
      for (int s = 0; s < 2; s++) begin
         go = 1'b1;
         for (int k = 1; k < int'(WIN_LEN); k++) begin
            rr = int'(row_q) + ((s == 0) ? k : -k) * dr;
            cc = int'(col_q) + ((s == 0) ? k : -k) * dc;
            if (go && rr >= 0 && rr < int'(ROWS) && cc >= 0 && cc < int'(COLS)) begin
               if (board_q[CIW'(rr * int'(COLS) + cc)] &&
                   (colors_q[CIW'(rr * int'(COLS) + cc)] == player_q)) begin
                  run_cnt_c = run_cnt_c + 1;
               end else begin
                  go = 1'b0;
               end
            end else begin
               go = 1'b0;
            end
         end
      end
   end

   assign win_c = (run_cnt_c >= int'(WIN_LEN));

   always_comb begin : next_state
      state_d   = state_q;
      board_d   = board_q;
      colors_d  = colors_q;
      sel_d     = sel_q;
      player_d  = player_q;
      over_d    = over_q;
      winner_d  = winner_q;
      tout_d    = tout_q;
      illegal_d = 1'b0;
      tleft_d   = tleft_q;
      depth_d   = depth_q;
      mcount_d  = mcount_q;
      row_d     = row_q;
      col_d     = col_q;
      dir_d     = dir_q;
      win_d     = win_q;

      case (state_q)
         S_INIT: begin
            board_d  = '0;
            colors_d = '0;
            sel_d    = CW'(COLS / 2);
            player_d = 1'b0;
            over_d   = 1'b0;
            winner_d = 2'b00;
            tout_d   = 1'b0;
            tleft_d  = 8'd0;
            depth_d  = '{default: '0};
            mcount_d = '0;
            row_d    = '0;
            col_d    = '0;
            dir_d    = 2'd0;
            win_d    = 1'b0;
            state_d  = S_START;
         end
         S_START: begin
            if (Start1 || Drop1) begin
               tleft_d = 8'(TURN_TICKS);
               state_d = S_MOVE;
            end
         end
         S_MOVE: begin
            if (drop_c) begin
               if (col_full_c) illegal_d = 1'b1;
               else            state_d   = S_PLACE;
            end else if (tick_to_c) begin
               tleft_d  = 8'd0;
               over_d   = 1'b1;
               tout_d   = 1'b1;
               winner_d = player_q ? 2'b01 : 2'b10;
               state_d  = S_END;
            end else begin
               if (Tick && (TURN_TICKS != 0)) tleft_d = tleft_q - 8'd1;
               if (left_c && !right_c && (sel_q != '0))
                  sel_d = sel_q - CW'(1);
               else if (right_c && !left_c && (sel_q != CW'(COLS - 1)))
                  sel_d = sel_q + CW'(1);
            end
         end
         S_PLACE: begin
            board_d[cell_c]  = 1'b1;
            colors_d[cell_c] = player_q;
            depth_d[sel_q]   = depth_q[sel_q] + RW'(1);
            mcount_d         = mcount_q + MCW'(1);
            row_d            = depth_q[sel_q];
            col_d            = sel_q;
            dir_d            = 2'd0;
            win_d            = 1'b0;
            state_d          = S_CHECK;
         end
         S_CHECK: begin
            dir_d = dir_q + 2'd1;
            win_d = win_q | win_c;
            if (dir_q == 2'd3) begin
               if (win_q || win_c) begin
                  over_d   = 1'b1;
                  winner_d = player_q ? 2'b10 : 2'b01;
                  state_d  = S_END;
               end else if (mcount_q == MCW'(NCELL)) begin
                  over_d   = 1'b1;
                  winner_d = 2'b00;
                  state_d  = S_END;
               end else begin
                  player_d = ~player_q;
                  sel_d    = CW'(COLS / 2);
                  tleft_d  = 8'(TURN_TICKS);
                  state_d  = S_MOVE;
               end
            end
         end
         S_END: begin
            if (Start1 || Start2) state_d = S_INIT;
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= S_INIT;
         board_q   <= '0;
         colors_q  <= '0;
         sel_q     <= CW'(COLS / 2);
         player_q  <= 1'b0;
         over_q    <= 1'b0;
         winner_q  <= 2'b00;
         tout_q    <= 1'b0;
         illegal_q <= 1'b0;
         tleft_q   <= 8'd0;
         depth_q   <= '{default: '0};
         mcount_q  <= '0;
         row_q     <= '0;
         col_q     <= '0;
         dir_q     <= 2'd0;
         win_q     <= 1'b0;
         start_q   <= 1'b0;
         end_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         board_q   <= board_d;
         colors_q  <= colors_d;
         sel_q     <= sel_d;
         player_q  <= player_d;
         over_q    <= over_d;
         winner_q  <= winner_d;
         tout_q    <= tout_d;
         illegal_q <= illegal_d;
         tleft_q   <= tleft_d;
         depth_q   <= depth_d;
         mcount_q  <= mcount_d;
         row_q     <= row_d;
         col_q     <= col_d;
         dir_q     <= dir_d;
         win_q     <= win_d;
         start_q   <= (state_d == S_START);
         end_q     <= (state_d == S_END);
      end
   end

   assign board        = board_q;
   assign colors       = colors_q;
   assign selected_col = sel_q;
   assign player       = player_q;
   assign game_over    = over_q;
   assign winner       = winner_q;
   assign timed_out    = tout_q;
   assign illegal_drop = illegal_q;
   assign turn_left    = tleft_q;
   assign start_state  = start_q;
   assign end_state    = end_q;

endmodule

// File: tb/tb_connect_n_engine.sv
// Bench for connect_n_engine: a 7x6/4/3-tick instance and a 9x7/5/no-timeout
// instance share stimulus; a whole-board reference model predicts every outcome.
module tb_connect_n_engine;

   logic Clk = 1'b0;
   logic Reset_n;
   logic Left1, Right1, Drop1, Start1, Left2, Right2, Drop2, Start2, Tick;

   logic [41:0] a_board, a_colors;
   logic [2:0]  a_sel;
   logic        a_player, a_over, a_tout, a_ill, a_start, a_end;
   logic [1:0]  a_win;
   logic [7:0]  a_tl;
   logic [62:0] b_board, b_colors;
   logic [3:0]  b_sel;
   logic        b_player, b_over, b_tout, b_ill, b_start, b_end;
   logic [1:0]  b_win;
   logic [7:0]  b_tl;

   always #5 Clk = ~Clk;

   connect_n_engine #(.COLS(7), .ROWS(6), .WIN_LEN(4), .TURN_TICKS(3)) u_a (
      .Clk(Clk), .Reset_n(Reset_n),
      .Left1(Left1), .Right1(Right1), .Drop1(Drop1), .Start1(Start1),
      .Left2(Left2), .Right2(Right2), .Drop2(Drop2), .Start2(Start2), .Tick(Tick),
      .board(a_board), .colors(a_colors), .selected_col(a_sel), .player(a_player),
      .game_over(a_over), .winner(a_win), .timed_out(a_tout), .illegal_drop(a_ill),
      .turn_left(a_tl), .start_state(a_start), .end_state(a_end));

   connect_n_engine #(.COLS(9), .ROWS(7), .WIN_LEN(5), .TURN_TICKS(0)) u_b (
      .Clk(Clk), .Reset_n(Reset_n),
      .Left1(Left1), .Right1(Right1), .Drop1(Drop1), .Start1(Start1),
      .Left2(Left2), .Right2(Right2), .Drop2(Drop2), .Start2(Start2), .Tick(Tick),
      .board(b_board), .colors(b_colors), .selected_col(b_sel), .player(b_player),
      .game_over(b_over), .winner(b_win), .timed_out(b_tout), .illegal_drop(b_ill),
      .turn_left(b_tl), .start_state(b_start), .end_state(b_end));

   int vectors = 0;
   int miscompares = 0;
   int tgt, NC, NR, WL, TT;
   int grid [7][9];
   int mc, cur, pl, over, win, tout, tl;

   logic [63:0] ob_board, ob_colors;
   logic [3:0]  ob_sel;
   logic        ob_player, ob_over, ob_tout, ob_ill, ob_start, ob_end;
   logic [1:0]  ob_win;
   logic [7:0]  ob_tl;

   assign ob_board  = (tgt != 0) ? 64'(b_board)  : 64'(a_board);
   assign ob_colors = (tgt != 0) ? 64'(b_colors) : 64'(a_colors);
   assign ob_sel    = (tgt != 0) ? b_sel         : 4'(a_sel);
   assign ob_player = (tgt != 0) ? b_player : a_player;
   assign ob_over   = (tgt != 0) ? b_over   : a_over;
   assign ob_tout   = (tgt != 0) ? b_tout   : a_tout;
   assign ob_ill    = (tgt != 0) ? b_ill    : a_ill;
   assign ob_start  = (tgt != 0) ? b_start  : a_start;
   assign ob_end    = (tgt != 0) ? b_end    : a_end;
   assign ob_win    = (tgt != 0) ? b_win    : a_win;
   assign ob_tl     = (tgt != 0) ? b_tl     : a_tl;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_in();
      {Left1, Right1, Drop1, Start1, Left2, Right2, Drop2, Start2, Tick} = '0;
   endtask

   // k: 0 left, 1 right, 2 drop, 3 start, 4 tick
   task automatic press(input int p, input int k);
      case (k)
         0: if (p == 0) Left1  = 1'b1; else Left2  = 1'b1;
         1: if (p == 0) Right1 = 1'b1; else Right2 = 1'b1;
         2: if (p == 0) Drop1  = 1'b1; else Drop2  = 1'b1;
         3: if (p == 0) Start1 = 1'b1; else Start2 = 1'b1;
         default: Tick = 1'b1;
      endcase
      cyc(1);
      clear_in();
   endtask

   task automatic set_tgt(input int t);
      tgt = t;
      NC  = (t != 0) ? 9 : 7;
      NR  = (t != 0) ? 7 : 6;
      WL  = (t != 0) ? 5 : 4;
      TT  = (t != 0) ? 0 : 3;
   endtask

   function automatic int height(input int c);
      int h = 0;
      for (int r = 0; r < NR; r++) if (grid[r][c] != 0) h++;
      return h;
   endfunction

   // Any WIN_LEN line of colour p anywhere on the board.
   function automatic bit line_win(input int p);
      int drs [4] = '{0, 1, 1, -1};
      int dcs [4] = '{1, 0, 1, 1};
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            for (int d = 0; d < 4; d++) begin
               int n = 0;
               for (int k = 0; k < WL; k++) begin
                  int rr = r + k * drs[d];
                  int cc = c + k * dcs[d];
                  if (rr >= 0 && rr < NR && cc < NC && grid[rr][cc] == p) n++;
               end
               if (n == WL) return 1'b1;
            end
      return 1'b0;
   endfunction

   task automatic model_new();
      for (int r = 0; r < 7; r++) for (int c = 0; c < 9; c++) grid[r][c] = 0;
      mc = 0; cur = NC / 2; pl = 0; over = 0; win = 0; tout = 0; tl = 0;
   endtask

   task automatic model_drop(input int c);
      grid[height(c)][c] = pl + 1;
      mc++;
      if (line_win(pl + 1)) begin
         over = 1; win = (pl != 0) ? 2 : 1;
      end else if (mc == NR * NC) begin
         over = 1; win = 0;
      end else begin
         pl = 1 - pl; cur = NC / 2; tl = TT;
      end
   endtask

   task automatic model_tick();
      if (TT != 0) begin
         tl--;
         if (tl == 0) begin
            over = 1; win = (pl != 0) ? 1 : 2; tout = 1;
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [63:0] eb, ec;
      eb = '0;
      ec = '0;
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) begin
            if (grid[r][c] != 0) eb[NC * r + c] = 1'b1;
            if (grid[r][c] == 2) ec[NC * r + c] = 1'b1;
         end
      chk({tag, ".board"},     ob_board,         eb);
      chk({tag, ".colors"},    ob_colors,        ec);
      chk({tag, ".sel"},       64'(ob_sel),      64'(cur));
      chk({tag, ".player"},    64'(ob_player),   64'(pl));
      chk({tag, ".game_over"}, 64'(ob_over),     64'(over));
      chk({tag, ".winner"},    64'(ob_win),      64'(win));
      chk({tag, ".timed_out"}, 64'(ob_tout),     64'(tout));
      chk({tag, ".turn_left"}, 64'(ob_tl),       64'(tl));
      chk({tag, ".end_state"}, 64'(ob_end),      64'(over));
   endtask

   task automatic begin_game(input int t, input int use_drop);
      set_tgt(t);
      clear_in();
      Reset_n = 1'b0;
      cyc(1);
      Reset_n = 1'b1;
      cyc(1);
      model_new();
      chk("start.start_state", 64'(ob_start), 64'd1);
      press(0, (use_drop != 0) ? 2 : 3);
      tl = TT;
      check_all("start");
   endtask

   task automatic do_move(input int col);
      while (cur != col) begin
         if (cur < col) begin press(pl, 1); cur++; end
         else           begin press(pl, 0); cur--; end
      end
      chk("nav.sel", 64'(ob_sel), 64'(cur));
      if (height(col) == NR) begin
         press(pl, 2);
         chk("full.illegal",   64'(ob_ill),    64'd1);
         chk("full.player",    64'(ob_player), 64'(pl));
         chk("full.end_state", 64'(ob_end),    64'd0);
         chk("full.turn_left", 64'(ob_tl),     64'(tl));
         cyc(1);
         chk("full.pulse_end", 64'(ob_ill),    64'd0);
      end else begin
         press(pl, 2);
         cyc(4);
         chk("latency.end_state", 64'(ob_end),    64'd0);
         chk("latency.player",    64'(ob_player), 64'(pl));
         cyc(1);
         model_drop(col);
         check_all("move");
      end
   endtask

   task automatic random_game(input int t);
      int a, col;
      begin_game(t, int'($urandom_range(0, 1)));
      for (int i = 0; i < 200 && over == 0; i++) begin
         a = int'($urandom_range(0, 5));
         if (a == 0) begin
            if (pl == 0) begin Left1 = 1'b1; Right1 = 1'b1; end
            else         begin Left2 = 1'b1; Right2 = 1'b1; end
            cyc(1);
            clear_in();
            chk("lr_both.sel", 64'(ob_sel), 64'(cur));
         end else if (a == 1) begin
            press(1 - pl, int'($urandom_range(0, 2)));
            check_all("opponent");
         end else if (a == 2 && (TT == 0 || tl > 1)) begin
            press(pl, 4);
            model_tick();
            chk("tick.turn_left", 64'(ob_tl), 64'(tl));
         end
         col = int'($urandom_range(0, NC - 1));
         if ($urandom_range(0, 7) != 0)
            while (height(col) == NR) col = (col + 1) % NC;
         do_move(col);
      end
      chk("rand.game_over", 64'(ob_over), 64'd1);
   endtask

   int vert_cols [7]  = '{0, 1, 0, 1, 0, 1, 0};
   int diag_cols [20] = '{3, 3, 2, 4, 2, 2, 1, 6, 1, 6, 1, 1, 0, 7, 0, 7, 0, 8, 0, 0};
   int pairs [3][2]   = '{'{0, 2}, '{1, 3}, '{4, 6}};

   initial begin
      clear_in();
      set_tgt(0);
      Reset_n = 1'b0;
      cyc(2);
      model_new();
      check_all("reset");
      chk("reset.start_state", 64'(ob_start), 64'd0);
      chk("reset.illegal",     64'(ob_ill),   64'd0);
      Reset_n = 1'b1;
      cyc(1);
      chk("init.start_state", 64'(ob_start), 64'd1);
      check_all("init");

      // Vertical win for red in column 0.
      begin_game(0, 0);
      foreach (vert_cols[i]) do_move(vert_cols[i]);
      chk("vert.winner", 64'(ob_win), 64'd1);

      // Start2 from END restarts; Tick outside MOVE is ignored.
      press(1, 3);
      cyc(1);
      model_new();
      chk("restart.start_state", 64'(ob_start), 64'd1);
      check_all("restart");
      press(0, 4);
      chk("start_tick.turn_left", 64'(ob_tl), 64'd0);

      // Full column 3 then an illegal drop that leaves the timer alone.
      begin_game(0, 0);
      for (int i = 0; i < 6; i++) do_move(3);
      press(0, 4);
      model_tick();
      do_move(3);
      chk("full.player0", 64'(ob_player), 64'd0);

      // Scripted no-win fill of the 7x6 board.
      begin_game(0, 1);
      for (int p = 0; p < 3; p++)
         for (int rep = 0; rep < 3; rep++) begin
            do_move(pairs[p][0]); do_move(pairs[p][1]);
            do_move(pairs[p][1]); do_move(pairs[p][0]);
         end
      for (int i = 0; i < 6; i++) do_move(5);
      chk("draw.winner",    64'(ob_win),  64'd0);
      chk("draw.game_over", 64'(ob_over), 64'd1);
      chk("draw.timed_out", 64'(ob_tout), 64'd0);

      // Red idles through three Ticks and forfeits.
      begin_game(0, 0);
      for (int i = 0; i < 3; i++) begin
         press(0, 4);
         model_tick();
         check_all("timeout");
      end
      chk("timeout.winner", 64'(ob_win), 64'd2);

      // Drop and Tick in the same cycle: the drop is taken.
      begin_game(0, 0);
      press(0, 4); model_tick();
      press(0, 4); model_tick();
      Drop1 = 1'b1;
      Tick  = 1'b1;
      cyc(1);
      clear_in();
      cyc(5);
      model_drop(cur);
      check_all("drop_tick");

      // Player-2 input on red's turn, then async reset in the middle of CHECK.
      begin_game(0, 0);
      press(1, 0);
      chk("left2.sel", 64'(ob_sel), 64'(cur));
      press(0, 2);
      cyc(2);
      Reset_n = 1'b0;
      #1;
      model_new();
      check_all("async_rst");
      chk("async_rst.start_state", 64'(ob_start), 64'd0);
      chk("async_rst.illegal",     64'(ob_ill),   64'd0);
      cyc(1);
      Reset_n = 1'b1;

      // 9x7 board, WIN_LEN 5: black builds a falling diagonal.
      begin_game(1, 0);
      foreach (diag_cols[i]) begin
         do_move(diag_cols[i]);
         if (i == 11) chk("diag4.game_over", 64'(ob_over), 64'd0);
      end
      chk("diag5.winner", 64'(ob_win), 64'd2);

      for (int g = 0; g < 3; g++) random_game(0);
      for (int g = 0; g < 2; g++) random_game(1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
